short_preamble_inserter: RTL and testbench



---
 rtl/short_preamble_inserter.sv | 134 +++++++++++++
 tb/tb_short_preamble_inserter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/short_preamble_inserter.sv
// Prepends NUM_REPS copies of the 802.11a short training symbol to each payload burst,
// then passes the payload through with zero latency.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for i_tvalid; no input consumed, no output
// PREAMBLE | emitting ROM samples (registered), o_tuser high
// PAYLOAD  | combinational pass-through until a handshake with i_tlast
module short_preamble_inserter #(
    parameter int WIDTH       = 32,
    parameter int SYMBOL_LEN  = 16,
    parameter int NUM_REPS    = 10,
    parameter int SCALE_SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tuser,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_busy
);

    localparam int IDX_W = $clog2(SYMBOL_LEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [7:0]       rep;
    logic [WIDTH-1:0] pre_data;
    logic             pre_valid;
    logic             busy;
    logic             last_idx;
    logic             last_rep;

    // The short symbol has a 16-sample period, so other symbol lengths index it modulo 16.
    function automatic logic [WIDTH-1:0] rom_sample(input logic [IDX_W-1:0] k);
        logic signed [15:0] ri;
        logic signed [15:0] rq;
        logic [3:0]         k4;
        logic [WIDTH-1:0]   s;
        k4 = 4'(k);
        ri = '0;
        rq = '0;
        case (k4)
            4'd0:    begin ri =  16'sd1507; rq =  16'sd1507; end
            4'd1:    begin ri = -16'sd4325; rq =  16'sd66;   end
            4'd2:    begin ri = -16'sd426;  rq = -16'sd2589; end
            4'd3:    begin ri =  16'sd4686; rq = -16'sd426;  end
            4'd4:    begin ri =  16'sd3015; rq =  16'sd0;    end
            4'd5:    begin ri =  16'sd4686; rq = -16'sd426;  end
            4'd6:    begin ri = -16'sd426;  rq = -16'sd2589; end
            4'd7:    begin ri = -16'sd4325; rq =  16'sd66;   end
            4'd8:    begin ri =  16'sd1507; rq =  16'sd1507; end
            4'd9:    begin ri =  16'sd66;   rq = -16'sd4325; end
            4'd10:   begin ri = -16'sd2589; rq = -16'sd426;  end
            4'd11:   begin ri = -16'sd426;  rq =  16'sd4686; end
            4'd12:   begin ri =  16'sd0;    rq =  16'sd3015; end
            4'd13:   begin ri = -16'sd426;  rq =  16'sd4686; end
            4'd14:   begin ri = -16'sd2589; rq = -16'sd426;  end
            default: begin ri =  16'sd66;   rq = -16'sd4325; end
        endcase
        ri = ri >>> SCALE_SHIFT;
        rq = rq >>> SCALE_SHIFT;
        s = '0;
        s[31:0] = {ri, rq};
        return s;
    endfunction

    assign idx_nxt  = idx + 1'b1;
    assign last_idx = (idx == IDX_W'(SYMBOL_LEN - 1));
    assign last_rep = (rep == 8'(NUM_REPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            rep       <= '0;
            pre_data  <= '0;
            pre_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_tvalid) begin
                        state <= PREAMBLE;
                        busy  <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    // First cycle in PREAMBLE only primes the ROM register.
                    if (!pre_valid) begin
                        pre_data  <= rom_sample(idx);
                        pre_valid <= 1'b1;
                    end else if (o_tready) begin
                        if (last_idx && last_rep) begin
                            state     <= PAYLOAD;
                            idx       <= '0;
                            rep       <= '0;
                            pre_data  <= '0;
                            pre_valid <= 1'b0;
                        end else begin
                            idx      <= idx_nxt;
                            pre_data <= rom_sample(idx_nxt);
                            if (last_idx) rep <= rep + 8'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (i_tvalid && o_tready && i_tlast) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_tready = (state == PAYLOAD) && o_tready;
    assign o_tdata  = (state == PAYLOAD) ? i_tdata : pre_data;
    assign o_tvalid = (state == PAYLOAD) ? i_tvalid : pre_valid;
    assign o_tlast  = (state == PAYLOAD) && i_tlast;
    assign o_tuser  = pre_valid;
    assign o_busy   = busy;

endmodule

// File: tb/tb_short_preamble_inserter.sv
// Bench for short_preamble_inserter: scoreboarded bursts, reset abort, idle pulse,
// and a scaled two-repetition instance.
module tb_short_preamble_inserter;

    localparam int SL  = 16;
    localparam int NR  = 10;
    localparam int PRE = SL * NR;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } exp_t;

    typedef struct {
        int n1;
        int n2;
        bit rnd;
        int exp_hs;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tuser, o_tvalid, o_busy;
    logic        o_tready = 1'b1;

    logic [31:0] i2_tdata = '0;
    logic        i2_tlast = 1'b0;
    logic        i2_tvalid = 1'b0;
    logic        i2_tready;
    logic [31:0] o2_tdata;
    logic        o2_tlast, o2_tuser, o2_tvalid, o2_busy;
    logic        o2_tready = 1'b1;

    short_preamble_inserter dut (
        .clk(clk), .reset(reset),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tuser(o_tuser), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .o_busy(o_busy)
    );

    short_preamble_inserter #(.WIDTH(32), .SYMBOL_LEN(16), .NUM_REPS(2), .SCALE_SHIFT(2)) dut2 (
        .clk(clk), .reset(reset),
        .i_tdata(i2_tdata), .i_tlast(i2_tlast), .i_tvalid(i2_tvalid), .i_tready(i2_tready),
        .o_tdata(o2_tdata), .o_tlast(o2_tlast), .o_tuser(o2_tuser), .o_tvalid(o2_tvalid),
        .o_tready(o2_tready), .o_busy(o2_busy)
    );

    // 802.11a short training symbol, round(32768 * STS(k))
    logic signed [15:0] rom_i [16] = '{16'sd1507, -16'sd4325, -16'sd426, 16'sd4686,
                                       16'sd3015, 16'sd4686, -16'sd426, -16'sd4325,
                                       16'sd1507, 16'sd66, -16'sd2589, -16'sd426,
                                       16'sd0, -16'sd426, -16'sd2589, 16'sd66};
    logic signed [15:0] rom_q [16] = '{16'sd1507, 16'sd66, -16'sd2589, -16'sd426,
                                       16'sd0, -16'sd426, -16'sd2589, 16'sd66,
                                       16'sd1507, -16'sd4325, -16'sd426, 16'sd4686,
                                       16'sd3015, 16'sd4686, -16'sd426, -16'sd4325};

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   tv_rise_cyc = 0;
    int   hs_cnt = 0;
    int   pre_cnt = 0;
    int   idle_run = 0;
    int   last_idle_run = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] d, input logic l, input logic u);
        exp_t e;
        e.data = d;
        e.last = l;
        e.user = u;
        return e;
    endfunction

    function automatic logic [31:0] pay(input int v);
        return {16'(v), 16'(v)};
    endfunction

    task automatic push_preamble();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < SL; k++)
                sb.push_back(mk({rom_i[k], rom_q[k]}, 1'b0, 1'b1));
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic monitor();
        logic        prev_stall = 1'b0;
        logic        prev_valid = 1'b0;
        logic [31:0] prev_data = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
                idle_run   = 0;
                continue;
            end
            if (prev_stall) begin
                tests++;
                if (!o_tvalid || o_tdata !== prev_data) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             o_tvalid, o_tdata, prev_data);
                end
            end
            if (o_tvalid && o_tuser && !prev_valid) begin
                tests++;
                if (cyc - tv_rise_cyc != 2) begin
                    fails++;
                    $display("FAIL first_latency: got %0d cycles, required 2", cyc - tv_rise_cyc);
                end
            end
            if (o_tvalid && o_tready) begin
                hs_cnt++;
                if (o_tuser) pre_cnt++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: data=%h last=%b user=%b, required no output",
                             o_tdata, o_tlast, o_tuser);
                end else begin
                    e = sb.pop_front();
                    if (o_tdata !== e.data || o_tlast !== e.last || o_tuser !== e.user) begin
                        fails++;
                        $display("FAIL out_sample %0d: data=%h last=%b user=%b, required data=%h last=%b user=%b",
                                 hs_cnt, o_tdata, o_tlast, o_tuser, e.data, e.last, e.user);
                    end
                end
            end
            if (!o_busy) idle_run++;
            else if (idle_run != 0) begin
                last_idle_run = idle_run;
                idle_run = 0;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_valid = o_tvalid;
            prev_data  = o_tdata;
        end
    endtask

    task automatic drive_payload(input int n, input int base);
        int k = 0;
        int budget = 0;
        for (int j = 1; j <= n; j++) sb.push_back(mk(pay(base + j), j == n, 1'b0));
        tv_rise_cyc = cyc;
        i_tdata  = pay(base + 1);
        i_tlast  = (n == 1);
        i_tvalid = 1'b1;
        while (k < n && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (i_tready) k++;
            @(posedge clk);
            #1;
            if (k < n) begin
                i_tdata = pay(base + k + 1);
                i_tlast = (k == n - 1);
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = '0;
        tests++;
        if (k < n) begin
            fails++;
            $display("FAIL drive_timeout: sent %0d of %0d payload samples", k, n);
        end
    endtask

    vec_t vecs[4];
    int   hs0, p0, n2, budget;
    bit   ok, done;
    logic signed [15:0] ei, eq;

    initial begin
        vecs[0] = '{5, 0, 1'b0, PRE + 5};
        vecs[1] = '{7, 0, 1'b1, PRE + 7};
        vecs[2] = '{1, 4, 1'b0, 2 * PRE + 5};
        vecs[3] = '{3, 2, 1'b1, 2 * PRE + 5};

        fork
            monitor();
            ready_gen();
        join_none

        repeat (2) @(negedge clk);
        tests++;
        if ({o_tdata, o_tvalid, o_tuser, o_tlast, o_busy, i_tready} !== '0) begin
            fails++;
            $display("FAIL reset_state: data=%h valid=%b user=%b last=%b busy=%b ready=%b, required all 0",
                     o_tdata, o_tvalid, o_tuser, o_tlast, o_busy, i_tready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            rand_ready = vecs[v].rnd;
            hs0 = hs_cnt;
            push_preamble();
            drive_payload(vecs[v].n1, v * 16);
            if (vecs[v].n2 > 0) begin
                push_preamble();
                drive_payload(vecs[v].n2, v * 16 + 8);
            end
            repeat (3) @(posedge clk);
            #1;
            tests++;
            if (hs_cnt - hs0 != vecs[v].exp_hs) begin
                fails++;
                $display("FAIL vec%0d_handshakes: got %0d, required %0d", v, hs_cnt - hs0, vecs[v].exp_hs);
            end
            tests++;
            if (sb.size() != 0) begin
                fails++;
                $display("FAIL vec%0d_leftover: %0d expected samples unseen, required 0", v, sb.size());
            end
            if (vecs[v].n2 > 0) begin
                tests++;
                if (last_idle_run != 1) begin
                    fails++;
                    $display("FAIL vec%0d_idle_gap: got %0d cycles, required 1", v, last_idle_run);
                end
            end
        end
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // one-cycle i_tvalid pulse still yields a full preamble, then PAYLOAD waits
        hs0 = hs_cnt;
        push_preamble();
        i_tdata = pay(16'h70);
        i_tvalid = 1'b1;
        tv_rise_cyc = cyc;
        @(posedge clk);
        #1 i_tvalid = 1'b0;
        budget = 0;
        while (hs_cnt - hs0 < PRE && budget < 400) begin
            @(posedge clk);
            budget++;
        end
        #1;
        tests++;
        if (hs_cnt - hs0 != PRE) begin
            fails++;
            $display("FAIL pulse_preamble: got %0d samples, required %0d", hs_cnt - hs0, PRE);
        end
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (o_tvalid || !o_busy) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL pulse_wait: valid=%b busy=%b, required valid=0 busy=1", o_tvalid, o_busy);
        end
        @(posedge clk);
        #1;
        drive_payload(3, 16'h70);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (hs_cnt - hs0 != PRE + 3 || sb.size() != 0) begin
            fails++;
            $display("FAIL pulse_total: got %0d handshakes %0d pending, required %0d and 0",
                     hs_cnt - hs0, sb.size(), PRE + 3);
        end

        // reset mid-preamble abandons the burst
        p0 = pre_cnt;
        push_preamble();
        i_tdata = pay(16'h90);
        i_tlast = 1'b1;
        i_tvalid = 1'b1;
        tv_rise_cyc = cyc;
        budget = 0;
        while (pre_cnt - p0 < 70 && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        #1;
        tests++;
        if (pre_cnt - p0 < 70) begin
            fails++;
            $display("FAIL reset_reach70: got %0d samples, required 70", pre_cnt - p0);
        end
        reset = 1'b1;
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({o_tdata, o_tvalid, o_tuser, o_tlast, o_busy} !== '0) begin
                fails++;
                $display("FAIL in_reset_out: data=%h valid=%b user=%b last=%b busy=%b, required all 0",
                         o_tdata, o_tvalid, o_tuser, o_tlast, o_busy);
            end
        end
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        hs0 = hs_cnt;
        push_preamble();
        drive_payload(2, 16'h40);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (hs_cnt - hs0 != PRE + 2 || sb.size() != 0) begin
            fails++;
            $display("FAIL post_reset_total: got %0d handshakes %0d pending, required %0d and 0",
                     hs_cnt - hs0, sb.size(), PRE + 2);
        end

        // scaled, two-repetition instance
        i2_tdata = 32'hABCD1234;
        i2_tlast = 1'b1;
        i2_tvalid = 1'b1;
        n2 = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (o2_tvalid && o2_tuser) begin
                ei = rom_i[n2 % 16] >>> 2;
                eq = rom_q[n2 % 16] >>> 2;
                tests++;
                if (o2_tdata !== {ei, eq} || o2_tlast !== 1'b0) begin
                    fails++;
                    $display("FAIL scaled_sample %0d: data=%h last=%b, required data=%h last=0",
                             n2, o2_tdata, o2_tlast, {ei, eq});
                end
                if (n2 == 0) begin
                    tests++;
                    if (o2_tdata !== 32'h01780178) begin
                        fails++;
                        $display("FAIL scaled_first: got %h, required 01780178", o2_tdata);
                    end
                end
                if (n2 == 1) begin
                    tests++;
                    if (o2_tdata[31:16] !== 16'hFBC6) begin
                        fails++;
                        $display("FAIL scaled_negative: got %h, required FBC6", o2_tdata[31:16]);
                    end
                end
                n2++;
            end else if (o2_tvalid) begin
                tests++;
                if (o2_tdata !== 32'hABCD1234 || o2_tlast !== 1'b1) begin
                    fails++;
                    $display("FAIL scaled_payload: data=%h last=%b, required ABCD1234 last=1",
                             o2_tdata, o2_tlast);
                end
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        i2_tvalid = 1'b0;
        i2_tlast = 1'b0;
        tests++;
        if (n2 != 32 || !done) begin
            fails++;
            $display("FAIL scaled_count: got %0d preamble samples payload_seen=%b, required 32 and 1",
                     n2, done);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
